riscv_irq_generator: RTL



---
 rtl/riscv_irq_generator_pkg.sv | 14 +
 rtl/riscv_irq_generator_if.sv | 20 ++
 rtl/riscv_irq_generator_lfsr.sv | 31 +++
 rtl/riscv_irq_generator.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/riscv_irq_generator_pkg.sv
// Shared types and constants for the bench-side RI5CY interrupt generator.
package irq_gen_pkg;

  localparam int          IRQ_ID_W     = 5;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } irq_gen_state_e;

endpackage

// File: rtl/riscv_irq_generator_if.sv
// Level interrupt request / acknowledge pair between the generator and the core.
interface riscv_irq_generator_if;

  logic                               irq;
  logic [irq_gen_pkg::IRQ_ID_W-1:0]   irq_id;
  logic                               irq_sec;
  logic                               irq_ack;
  logic [irq_gen_pkg::IRQ_ID_W-1:0]   ack_id;

  modport master (
    output irq, irq_id, irq_sec,
    input  irq_ack, ack_id
  );

  modport slave (
    input  irq, irq_id, irq_sec,
    output irq_ack, ack_id
  );

endinterface

// File: rtl/riscv_irq_generator_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with seed load and step enable.
// Latency: state updates on the edge after load/step.
// Backpressure: none; load overrides step, a zero seed falls back to the reset seed.
module irq_lfsr16
  import irq_gen_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = irq_gen_pkg::DEFAULT_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET_SEED;
    end else if (load) begin
      state_q <= (seed == 16'd0) ? RESET_SEED : seed;
    end else if (step) begin
      state_q <= {state_q[14:0], ^(state_q & LFSR_TAPS)};
    end
  end

  assign state = state_q;

endmodule

// File: rtl/riscv_irq_generator.sv
// Random/directed interrupt source for RI5CY: pending vector, highest-ID level request, ack clear.
// Latency: set -> pending_o +1 cycle, irq +2 cycles; ack -> irq low +1, next irq earliest +3.
// Backpressure: request held frozen until a matching ack; sets keep accumulating meanwhile.
module riscv_irq_generator #(
  parameter int          NUM_IRQ      = 32,
  parameter logic [15:0] DEFAULT_SEED = irq_gen_pkg::DEFAULT_SEED
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [1:0]                       mode_i,
  input  logic                             set_valid_i,
  input  logic [irq_gen_pkg::IRQ_ID_W-1:0] set_id_i,
  input  logic                             set_sec_i,
  input  logic                             seed_load_i,
  input  logic [15:0]                      seed_i,
  input  logic [7:0]                       min_gap_i,
  input  logic [7:0]                       gap_mask_i,
  riscv_irq_generator_if.master            core,
  output logic [NUM_IRQ-1:0]               pending_o,
  output logic                             ack_err_o,
  output logic [31:0]                      irq_count_o
);

  import irq_gen_pkg::*;

  irq_gen_state_e      state_q, state_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d, sec_q, sec_d, set_mask, clr_mask;
  logic [IRQ_ID_W-1:0] id_q, hi_idx;
  logic                id_sec_q;
  logic [8:0]          gap_cnt_q, gap_reload;
  logic [15:0]         lfsr;
  logic                lfsr_unused;
  logic                dir_set, rnd_set;
  logic                latch_en, ack_ok, ack_err_d, ack_err_q;
  logic [31:0]         count_q;

  irq_lfsr16 #(
    .RESET_SEED(DEFAULT_SEED)
  ) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (seed_load_i),
    .seed  (seed_i),
    .step  (mode_i[1]),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:8];

  assign dir_set    = set_valid_i & mode_i[0];
  assign rnd_set    = mode_i[1] & (gap_cnt_q == 9'd0);
  assign gap_reload = {1'b0, min_gap_i} + {1'b0, lfsr[7:0] & gap_mask_i};

  // Directed set is applied last so its secure bit wins on an ID collision.
  always_comb begin
    set_mask = '0;
    sec_d    = sec_q;
    if (rnd_set) begin
      set_mask[lfsr[4:0]] = 1'b1;
      sec_d[lfsr[4:0]]    = lfsr[5];
    end
    if (dir_set) begin
      set_mask[set_id_i] = 1'b1;
      sec_d[set_id_i]    = set_sec_i;
    end
  end

  // Set after clear: a same-cycle set of the acknowledged ID keeps it pending.
  always_comb begin
    clr_mask = '0;
    if (ack_ok) begin
      clr_mask[id_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending_q[i]) begin
        hi_idx = i[IRQ_ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    ack_ok    = 1'b0;
    ack_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        ack_err_d = core.irq_ack;
        if ((mode_i != 2'b00) && (|pending_q)) begin
          latch_en = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (core.irq_ack) begin
          if (core.ack_id == id_q) begin
            ack_ok  = 1'b1;
            state_d = GAP;
          end else begin
            ack_err_d = 1'b1;
          end
        end
      end
      GAP: begin
        ack_err_d = core.irq_ack;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      sec_q     <= '0;
      id_q      <= '0;
      id_sec_q  <= 1'b0;
      ack_err_q <= 1'b0;
      count_q   <= '0;
      gap_cnt_q <= {1'b0, min_gap_i};
    end else begin
      pending_q <= pending_d;
      sec_q     <= sec_d;
      ack_err_q <= ack_err_d;
      if (latch_en) begin
        id_q     <= hi_idx;
        id_sec_q <= sec_q[hi_idx];
      end
      if (ack_ok) begin
        count_q <= count_q + 32'd1;
      end
      if (mode_i[1]) begin
        gap_cnt_q <= rnd_set ? gap_reload : gap_cnt_q - 9'd1;
      end
    end
  end

  assign core.irq     = (state_q == REQ);
  assign core.irq_id  = id_q;
  assign core.irq_sec = id_sec_q;
  assign pending_o    = pending_q;
  assign ack_err_o    = ack_err_q;
  assign irq_count_o  = count_q;

endmodule
